// File: rtl/branch_resolve.sv
// Purpose: resolves BEQ/BNE/BLEZ/BGTZ from ALU flags, computes the branch target, flags mispredicts.
// Latency: 1 cycle from accepted branch to PCSrc/target/valid_out/mispredict.
// Backpressure: none upstream; o_flush squashes inputs for FLUSH_CYCLES after a mispredict.
// Optional feature: define BRANCH_PREDICT_EN to add a 2-bit BHT predictor (default: predict not-taken).
module branch_resolve #(
   parameter int ADDR_W       = 32,
   parameter int BHT_DEPTH    = 16,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid_in,
   input  logic              i_branch,
   input  logic [1:0]        i_branch_type,
   input  logic              i_zero,
   input  logic              i_negative,
   input  logic [ADDR_W-1:0] i_pc_in,
   input  logic [ADDR_W-1:0] i_imm_in,
   output logic              o_PCSrc,
   output logic [ADDR_W-1:0] o_target,
   output logic              o_valid_out,
   output logic              o_mispredict,
   output logic              o_flush,
   output logic [15:0]       o_taken_count
);

   localparam logic [1:0] BT_BEQ  = 2'b00;
   localparam logic [1:0] BT_BNE  = 2'b01;
   localparam logic [1:0] BT_BLEZ = 2'b10;

   logic              w_accept;
   logic              w_taken;
   logic              w_pred;
   logic [ADDR_W-1:0] w_target;
   logic [3:0]        r_flush_cnt;

   // Inputs are squashed while younger instructions are being flushed.
   assign o_flush  = (r_flush_cnt != 4'd0);
   assign w_accept = i_valid_in & i_branch & ~o_flush;

   // Word offset is scaled to bytes; overflow wraps silently.
   assign w_target = i_pc_in + ADDR_W'(4) + (i_imm_in << 2);

   // Branch condition from the ALU flags.
   always_comb begin
      w_taken = 1'b0;
      case (i_branch_type)
         BT_BEQ:  w_taken = i_zero;
         BT_BNE:  w_taken = ~i_zero;
         BT_BLEZ: w_taken = i_zero | i_negative;
         default: w_taken = ~i_zero & ~i_negative;
      endcase
   end

`ifdef BRANCH_PREDICT_EN
   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [1:0]       r_bht [BHT_DEPTH];
   logic [IDX_W-1:0] w_idx;

   assign w_idx  = i_pc_in[2 +: IDX_W];
   assign w_pred = r_bht[w_idx][1];

   // Train the 2-bit saturating counter on the same edge that registers the result.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            r_bht[i] <= 2'b01;
         end
      end else if (w_accept) begin
         if (w_taken && (r_bht[w_idx] != 2'b11)) begin
            r_bht[w_idx] <= r_bht[w_idx] + 2'b01;
         end else if (!w_taken && (r_bht[w_idx] != 2'b00)) begin
            r_bht[w_idx] <= r_bht[w_idx] - 2'b01;
         end
      end
   end
`else
   // Static not-taken prediction: every taken branch is a mispredict.
   assign w_pred = 1'b0;
`endif

   // Register the resolved branch; target holds its last value when idle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_PCSrc      <= 1'b0;
         o_valid_out  <= 1'b0;
         o_mispredict <= 1'b0;
         o_target     <= '0;
      end else begin
         o_PCSrc      <= w_accept & w_taken;
         o_valid_out  <= w_accept;
         o_mispredict <= w_accept & (w_taken != w_pred);
         if (w_accept) begin
            o_target <= w_target;
         end
      end
   end

   // Flush window: load on an accepted mispredict, count down to idle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_flush_cnt <= 4'd0;
      end else if (w_accept && (w_taken != w_pred)) begin
         r_flush_cnt <= 4'(FLUSH_CYCLES);
      end else if (r_flush_cnt != 4'd0) begin
         r_flush_cnt <= r_flush_cnt - 4'd1;
      end
   end

   // Saturating count of accepted taken branches.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_taken_count <= 16'd0;
      end else if (w_accept && w_taken && (o_taken_count != 16'hFFFF)) begin
         o_taken_count <= o_taken_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed plan cases plus randomized traffic against a behavioural model.
// Works in both builds; the taken_count saturation sweep needs the predictor to stay within a short run.
module tb_branch_resolve;

   localparam int ADDR_W = 32;
   localparam int DEPTH  = 16;
   localparam int FC     = 2;
`ifdef BRANCH_PREDICT_EN
   localparam bit PRED_EN = 1'b1;
`else
   localparam bit PRED_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              valid_in;
   logic              branch;
   logic [1:0]        branch_type;
   logic              zero;
   logic              negative;
   logic [ADDR_W-1:0] pc_in;
   logic [ADDR_W-1:0] imm_in;
   logic              pcsrc;
   logic [ADDR_W-1:0] target;
   logic              valid_out;
   logic              mispredict;
   logic              flush;
   logic [15:0]       taken_count;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model state
   int          m_flush_left;
   int          m_taken_cnt;
   int          m_bht [DEPTH];
   bit          m_valid, m_pcsrc, m_mis;
   logic [31:0] m_target;

   branch_resolve #(.ADDR_W(ADDR_W), .BHT_DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_valid_in    (valid_in),
      .i_branch      (branch),
      .i_branch_type (branch_type),
      .i_zero        (zero),
      .i_negative    (negative),
      .i_pc_in       (pc_in),
      .i_imm_in      (imm_in),
      .o_PCSrc       (pcsrc),
      .o_target      (target),
      .o_valid_out   (valid_out),
      .o_mispredict  (mispredict),
      .o_flush       (flush),
      .o_taken_count (taken_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit cond_taken(input logic [1:0] t, input bit z, input bit n);
      case (t)
         2'd0:    return z;
         2'd1:    return !z;
         2'd2:    return z || n;
         default: return !z && !n;
      endcase
   endfunction

   // One clock: inputs already driven; advance the model and compare after the edge.
   task automatic step(input bit do_chk);
      bit acc, tk, pred;
      int idx;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_flush_left = 0;
         m_taken_cnt  = 0;
         m_valid = 0; m_pcsrc = 0; m_mis = 0;
         m_target = 32'd0;
         for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
      end else begin
         acc = valid_in && branch && (m_flush_left == 0);
         if (m_flush_left > 0) m_flush_left--;
         m_valid = acc; m_pcsrc = 0; m_mis = 0;
         if (acc) begin
            tk   = cond_taken(branch_type, zero, negative);
            idx  = int'(pc_in / 4) % DEPTH;
            pred = PRED_EN ? (m_bht[idx] >= 2) : 1'b0;
            m_pcsrc  = tk;
            m_target = pc_in + 32'd4 + imm_in * 32'd4;
            m_mis    = (tk != pred);
            if (m_mis) m_flush_left = FC;
            if (tk && m_taken_cnt < 65535) m_taken_cnt++;
            if (PRED_EN) m_bht[idx] = tk ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                                         : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
         end
      end
      if (do_chk) begin
         chk("valid_out",   valid_out,   m_valid);
         chk("PCSrc",       pcsrc,       m_pcsrc);
         chk("mispredict",  mispredict,  m_mis);
         chk("target",      target,      m_target);
         chk("flush",       flush,       m_flush_left != 0);
         chk("taken_count", taken_count, m_taken_cnt[15:0]);
      end
   endtask

   task automatic drive(input bit v, input bit b, input logic [1:0] t, input bit z, input bit n,
                        input logic [31:0] pc, input logic [31:0] imm);
      valid_in = v; branch = b; branch_type = t; zero = z; negative = n; pc_in = pc; imm_in = imm;
   endtask

   task automatic idle();
      drive(0, 0, 2'd0, 0, 0, 32'd0, 32'd0);
   endtask

   // Wait out any flush window the model expects, bounded.
   task automatic drain();
      idle();
      for (int i = 0; i < 20 && m_flush_left > 0; i++) step(1);
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      idle();
      for (int i = 0; i < cycles; i++) step(1);
      rst_n = 1'b1;
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      idle();

      // Reset: two cycles low, all outputs zero.
      do_reset(2);
      chk("rst_valid", valid_out, 1'b0);
      chk("rst_flush", flush, 1'b0);
      chk("rst_target", target, 32'd0);
      chk("rst_count", taken_count, 16'd0);

      // BEQ taken, then a branch presented during the flush.
      drive(1, 1, 2'd0, 1, 0, 32'h100, 32'h3);
      step(1);
      chk("beq_pcsrc", pcsrc, 1'b1);
      chk("beq_target", target, 32'h110);
      chk("beq_mis", mispredict, 1'b1);
      chk("beq_flush1", flush, 1'b1);
      drive(1, 1, 2'd1, 0, 0, 32'h200, 32'h1);
      step(1);
      chk("squash_valid", valid_out, 1'b0);
      chk("squash_count", taken_count, 16'd1);
      chk("beq_flush2", flush, 1'b1);
      idle();
      step(1);
      chk("beq_flush_end", flush, 1'b0);

      // Condition matrix: 4 types x {00,01,10}; 6 taken cases in total.
      base = m_taken_cnt;
      for (int t = 0; t < 4; t++) begin
         for (int f = 0; f < 3; f++) begin
            drive(1, 1, 2'(t), f == 2, f == 1, 32'h400 + 32'(t * 16 + f * 4), 32'h10);
            step(1);
            chk("matrix_valid", valid_out, 1'b1);
            drain();
         end
      end
      chk("matrix_count", taken_count, 16'(base + 6));

      // Target wrap-around.
      drive(1, 1, 2'd0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
      step(1);
      chk("wrap1", target, 32'hFFFF_FFFC);
      drain();
      drive(1, 1, 2'd0, 0, 0, 32'hFFFF_FFF8, 32'h2);
      step(1);
      chk("wrap2", target, 32'h4);
      drain();

      // Non-branch instruction: no output.
      drive(1, 0, 2'd1, 0, 0, 32'h300, 32'h1);
      step(1);
      chk("nonbranch_valid", valid_out, 1'b0);

      // Reset together with a valid branch: reset wins.
      rst_n = 1'b0;
      drive(1, 1, 2'd1, 0, 0, 32'h500, 32'h1);
      step(1);
      chk("rst_wins_valid", valid_out, 1'b0);
      chk("rst_wins_count", taken_count, 16'd0);
      rst_n = 1'b1;

`ifdef BRANCH_PREDICT_EN
      // Predictor training on one PC: mispredict 1,0,0 then 1 on not-taken.
      begin
         bit exp_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
         for (int k = 0; k < 4; k++) begin
            drive(1, 1, 2'd1, k == 3, 0, 32'h0000_0640, 32'h8);
            step(1);
            chk("bht_mis", mispredict, exp_seq[k]);
            drain();
         end
      end
`endif

      // Mid-flush reset.
      do_reset(1);
      drive(1, 1, 2'd3, 0, 0, 32'h700, 32'h4);
      step(1);
      chk("midrst_flush_hi", flush, 1'b1);
      rst_n = 1'b0;
      idle();
      step(1);
      chk("midrst_flush_lo", flush, 1'b0);
      chk("midrst_count", taken_count, 16'd0);
      chk("midrst_valid", valid_out, 1'b0);
      rst_n = 1'b1;

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         bit z, n;
         z = ($urandom_range(0, 2) == 0);
         n = !z && ($urandom_range(0, 1) == 1);
         rst_n = ($urandom_range(0, 199) != 0);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)),
               z, n, {$urandom_range(0, 3) == 0 ? $urandom() : 32'h0} | 32'($urandom_range(0, 63) * 4),
               $urandom());
         step(1);
      end
      rst_n = 1'b1;
      drain();

`ifdef BRANCH_PREDICT_EN
      // taken_count saturation: a trained PC avoids flushes so the sweep stays short.
      do_reset(1);
      drive(1, 1, 2'd1, 0, 0, 32'h0000_0880, 32'h1);
      step(1);
      drain();
      drive(1, 1, 2'd1, 0, 0, 32'h0000_0880, 32'h1);
      for (int i = 1; i < 65535 && m_flush_left == 0; i++) step(0);
      step(1);
      chk("sat_pre", taken_count, 16'hFFFF);
      step(1);
      chk("sat_hold", taken_count, 16'hFFFF);
      rst_n = 1'b0;
      idle();
      step(1);
      chk("sat_rst", taken_count, 16'd0);
      rst_n = 1'b1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
